// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 exception/EPC controller.
package cp0_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE    = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RESTORE = 3'd4,
    RETURN  = 3'd5
  } state_t;

  localparam int unsigned CAUSE_SYSCALL  = 0;
  localparam int unsigned CAUSE_IRQ_BASE = 1;

  localparam logic [31:0] HANDLER_BASE_DEFAULT = 32'h0000_0100;
  localparam int unsigned VEC_SHIFT_DEFAULT    = 4;

endpackage

// File: rtl/irq_pending_unit.sv
// Interrupt edge detection, pending register with mask/clear, and a
// lowest-index-first priority encoder producing a cause code.
module irq_pending_unit
  import cp0_pkg::*;
#(
  parameter int unsigned NrOfIrq   = 4,
  parameter int unsigned CauseBits = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic [NrOfIrq-1:0]   irq,
  input  logic [NrOfIrq-1:0]   irq_mask,
  input  logic [NrOfIrq-1:0]   irq_clr,
  input  logic                 ack,
  input  logic [CauseBits-1:0] ack_code,
  output logic                 irq_any,
  output logic [CauseBits-1:0] irq_code
);

  logic [NrOfIrq-1:0] irq_prev;
  logic [NrOfIrq-1:0] pending;
  logic [NrOfIrq-1:0] rise;
  logic [NrOfIrq-1:0] active;
  logic [NrOfIrq-1:0] ack_mask;

  always_comb begin
    rise     = irq & ~irq_prev;
    active   = pending & irq_mask;
    irq_any  = |active;
    ack_mask = '0;
    for (int unsigned i = 0; i < NrOfIrq; i++) begin
      if (ack && (ack_code == CauseBits'(i + CAUSE_IRQ_BASE)))
        ack_mask[i] = 1'b1;
    end
    // Scan from the top so the lowest active index is the last one written.
    irq_code = '0;
    for (int unsigned i = NrOfIrq; i >= 1; i--) begin
      if (active[i-1])
        irq_code = CauseBits'(i - 1 + CAUSE_IRQ_BASE);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      irq_prev <= '0;
      pending  <= '0;
    end else if (Tick) begin
      irq_prev <= irq;
      pending  <= (pending & ~irq_clr & ~ack_mask) | rise;
    end
  end

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception entry/return sequencer driving the EPC register's D,
// ClockEnable and cs pins and redirecting fetch to handler / return PC.
module cp0_exception_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NrOfIrq     = 4,
  parameter int unsigned AddrBits    = 32,
  parameter int unsigned CauseBits   = 3,
  parameter logic [AddrBits-1:0] HandlerBase = AddrBits'(HANDLER_BASE_DEFAULT),
  parameter int unsigned VecShift    = VEC_SHIFT_DEFAULT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Tick,
  input  logic [NrOfIrq-1:0]   irq,
  input  logic [NrOfIrq-1:0]   irq_mask,
  input  logic [NrOfIrq-1:0]   irq_clr,
  input  logic                 syscall,
  input  logic                 eret,
  input  logic [AddrBits-1:0]  pc_current,
  output logic [AddrBits-1:0]  epc_d,
  output logic                 epc_we,
  output logic                 epc_cs,
  input  logic [AddrBits-1:0]  epc_q,
  output logic                 redirect,
  output logic [AddrBits-1:0]  redirect_pc,
  output logic                 stall,
  output logic                 in_handler,
  output logic [CauseBits-1:0] cause
);

  state_t               state;
  logic                 irq_any;
  logic [CauseBits-1:0] irq_code;
  logic                 ack;

  assign ack = Tick && (state == IDLE) && !syscall && irq_any;

  irq_pending_unit #(
    .NrOfIrq   (NrOfIrq),
    .CauseBits (CauseBits)
  ) u_pending (
    .Clock    (Clock),
    .Reset    (Reset),
    .Tick     (Tick),
    .irq      (irq),
    .irq_mask (irq_mask),
    .irq_clr  (irq_clr),
    .ack      (ack),
    .ack_code (irq_code),
    .irq_any  (irq_any),
    .irq_code (irq_code)
  );

  // epc_d and redirect_pc double as the captured save/return PC registers:
  // they are loaded on entry to the state that presents them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cause       <= '0;
      epc_d       <= '0;
      epc_we      <= 1'b0;
      epc_cs      <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      stall       <= 1'b0;
      in_handler  <= 1'b0;
    end else if (Tick) begin
      unique case (state)
        IDLE: begin
          if (syscall) begin
            cause  <= CauseBits'(CAUSE_SYSCALL);
            epc_d  <= pc_current + AddrBits'(4);
            epc_we <= 1'b1;
            stall  <= 1'b1;
            state  <= SAVE;
          end else if (irq_any) begin
            cause  <= irq_code;
            epc_d  <= pc_current;
            epc_we <= 1'b1;
            stall  <= 1'b1;
            state  <= SAVE;
          end
        end
        SAVE: begin
          epc_we      <= 1'b0;
          epc_d       <= '0;
          stall       <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= HandlerBase + (AddrBits'(cause) << VecShift);
          state       <= VECTOR;
        end
        VECTOR: begin
          redirect    <= 1'b0;
          redirect_pc <= '0;
          in_handler  <= 1'b1;
          state       <= HANDLER;
        end
        HANDLER: begin
          if (eret) begin
            in_handler <= 1'b0;
            epc_cs     <= 1'b1;
            stall      <= 1'b1;
            state      <= RESTORE;
          end
        end
        RESTORE: begin
          epc_cs      <= 1'b0;
          stall       <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= epc_q;
          state       <= RETURN;
        end
        RETURN: begin
          redirect    <= 1'b0;
          redirect_pc <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Table-driven bench with an expected-output scoreboard and a simple EPC
// register model hanging off the controller's D/ClockEnable/cs/Q pins.
module tb_cp0_exception_ctrl;

  typedef struct packed {
    logic [31:0] epc_d;
    logic        we;
    logic        cs;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        inh;
    logic [2:0]  cause;
  } out_t;

  typedef struct {
    logic        tick;
    logic [3:0]  irq;
    logic [3:0]  mask;
    logic [3:0]  clr;
    logic        sys;
    logic        eret;
    logic [31:0] pc;
    out_t        exp;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Tick = 1'b1;
  logic [3:0]  irq = '0;
  logic [3:0]  irq_mask = '1;
  logic [3:0]  irq_clr = '0;
  logic        syscall = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] pc_current = '0;
  logic [31:0] epc_d;
  logic        epc_we;
  logic        epc_cs;
  logic [31:0] epc_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        in_handler;
  logic [2:0]  cause;

  logic [31:0] epc_reg;
  vec_t        tbl[$];
  out_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;

  cp0_exception_ctrl #(
    .NrOfIrq     (4),
    .AddrBits    (32),
    .CauseBits   (3),
    .HandlerBase (32'h0000_0100),
    .VecShift    (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Tick        (Tick),
    .irq         (irq),
    .irq_mask    (irq_mask),
    .irq_clr     (irq_clr),
    .syscall     (syscall),
    .eret        (eret),
    .pc_current  (pc_current),
    .epc_d       (epc_d),
    .epc_we      (epc_we),
    .epc_cs      (epc_cs),
    .epc_q       (epc_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .in_handler  (in_handler),
    .cause       (cause)
  );

  always #5 Clock = ~Clock;

  // EPC register: Q bus floats (poisoned value here) unless cs is asserted.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) epc_reg <= '0;
    else if (Tick && epc_we) epc_reg <= epc_d;
  end
  assign epc_q = epc_cs ? epc_reg : 32'hDEAD_BEEF;

  function automatic out_t o_idle(input logic [2:0] c);
    return '{epc_d: 32'h0, we: 1'b0, cs: 1'b0, redir: 1'b0, rpc: 32'h0, stall: 1'b0, inh: 1'b0, cause: c};
  endfunction
  function automatic out_t o_save(input logic [31:0] d, input logic [2:0] c);
    return '{epc_d: d, we: 1'b1, cs: 1'b0, redir: 1'b0, rpc: 32'h0, stall: 1'b1, inh: 1'b0, cause: c};
  endfunction
  function automatic out_t o_vec(input logic [31:0] r, input logic [2:0] c);
    return '{epc_d: 32'h0, we: 1'b0, cs: 1'b0, redir: 1'b1, rpc: r, stall: 1'b0, inh: 1'b0, cause: c};
  endfunction
  function automatic out_t o_hnd(input logic [2:0] c);
    return '{epc_d: 32'h0, we: 1'b0, cs: 1'b0, redir: 1'b0, rpc: 32'h0, stall: 1'b0, inh: 1'b1, cause: c};
  endfunction
  function automatic out_t o_rst(input logic [2:0] c);
    return '{epc_d: 32'h0, we: 1'b0, cs: 1'b1, redir: 1'b0, rpc: 32'h0, stall: 1'b1, inh: 1'b0, cause: c};
  endfunction
  function automatic out_t o_ret(input logic [31:0] r, input logic [2:0] c);
    return o_vec(r, c);
  endfunction

  task automatic row(input logic t, input logic [3:0] i, input logic [3:0] m, input logic [3:0] c,
                     input logic s, input logic e, input logic [31:0] pc, input out_t o);
    vec_t v;
    v.tick = t; v.irq = i; v.mask = m; v.clr = c; v.sys = s; v.eret = e; v.pc = pc; v.exp = o;
    tbl.push_back(v);
  endtask

  task automatic check(input string name);
    out_t want, got;
    want = sb.pop_front();
    got  = '{epc_d: epc_d, we: epc_we, cs: epc_cs, redir: redirect, rpc: redirect_pc,
             stall: stall, inh: in_handler, cause: cause};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got d=%h we=%b cs=%b rd=%b rpc=%h st=%b ih=%b c=%0d, want d=%h we=%b cs=%b rd=%b rpc=%h st=%b ih=%b c=%0d",
               name, got.epc_d, got.we, got.cs, got.redir, got.rpc, got.stall, got.inh, got.cause,
               want.epc_d, want.we, want.cs, want.redir, want.rpc, want.stall, want.inh, want.cause);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge Clock);
    Tick = v.tick; irq = v.irq; irq_mask = v.mask; irq_clr = v.clr;
    syscall = v.sys; eret = v.eret; pc_current = v.pc;
    sb.push_back(v.exp);
    @(posedge Clock);
    #1;
    check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units, limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // irq[2] entry, syscall ignored in handler, return to 0x40
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(0));
    row(1, 4'h4, 4'hF, 4'h0, 0, 0, 32'h40,  o_idle(0));
    row(1, 4'h4, 4'hF, 4'h0, 0, 0, 32'h40,  o_save(32'h40, 3));
    row(1, 4'h4, 4'hF, 4'h0, 0, 0, 32'h44,  o_vec(32'h130, 3));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h48,  o_hnd(3));
    row(1, 4'h0, 4'hF, 4'h0, 1, 0, 32'h0,   o_hnd(3));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(3));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h40, 3));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(3));
    // syscall beats pending irq[0]; irq[0] taken after return
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h200, o_idle(3));
    row(1, 4'h1, 4'hF, 4'h0, 1, 0, 32'h200, o_save(32'h204, 0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h204, o_vec(32'h100, 0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h208, o_hnd(0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 1, 32'h208, o_rst(0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h204, 0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h300, o_save(32'h300, 1));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h304, o_vec(32'h110, 1));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(1));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(1));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h300, 1));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(1));
    // masked pending irq[1], then unmask
    row(1, 4'h2, 4'hD, 4'h0, 0, 0, 32'h500, o_idle(1));
    row(1, 4'h2, 4'hD, 4'h0, 0, 0, 32'h500, o_idle(1));
    row(1, 4'h2, 4'hF, 4'h0, 0, 0, 32'h500, o_save(32'h500, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_vec(32'h120, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h500, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(2));
    // set wins over simultaneous clear
    row(1, 4'h2, 4'hD, 4'h2, 0, 0, 32'h600, o_idle(2));
    row(1, 4'h2, 4'hD, 4'h0, 0, 0, 32'h600, o_idle(2));
    row(1, 4'h2, 4'hF, 4'h0, 0, 0, 32'h600, o_save(32'h600, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_vec(32'h120, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h600, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(2));
    // plain clear removes a masked pending bit
    row(1, 4'h2, 4'hD, 4'h0, 0, 0, 32'h0,   o_idle(2));
    row(1, 4'h2, 4'hD, 4'h2, 0, 0, 32'h0,   o_idle(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(2));
    // irq[1] and irq[3] together: lowest first, then irq[3]
    row(1, 4'hA, 4'hF, 4'h0, 0, 0, 32'h700, o_idle(2));
    row(1, 4'hA, 4'hF, 4'h0, 0, 0, 32'h700, o_save(32'h700, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_vec(32'h120, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h700, 2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(2));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h800, o_save(32'h800, 4));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_vec(32'h140, 4));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(4));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(4));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_ret(32'h800, 4));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_idle(4));
    // syscall at top of memory wraps, then Tick=0 freeze in SAVE
    row(1, 4'h0, 4'hF, 4'h0, 1, 0, 32'hFFFF_FFFC, o_save(32'h0, 0));
    for (int k = 0; k < 5; k++)
      row(0, 4'h0, 4'hF, 4'h0, 1, 1, 32'h40, o_save(32'h0, 0));
    row(1, 4'h0, 4'hF, 4'h0, 0, 0, 32'h0,   o_vec(32'h100, 0));
    row(1, 4'h1, 4'hF, 4'h0, 0, 0, 32'h0,   o_hnd(0));
    row(1, 4'h0, 4'hF, 4'h0, 0, 1, 32'h0,   o_rst(0));

    // asynchronous reset state
    #1 Reset = 1'b1;
    #2;
    sb.push_back(o_idle(0));
    check("reset_state");
    @(negedge Clock);
    Reset = 1'b0;

    for (int k = 0; k < tbl.size(); k++)
      apply(tbl[k], $sformatf("vec%0d", k));

    // reset mid-RESTORE (pending[0] was set during the handler)
    #2 Reset = 1'b1;
    #1;
    sb.push_back(o_idle(0));
    check("reset_mid_restore");
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    begin
      vec_t v;
      v.tick = 1; v.irq = 4'h0; v.mask = 4'hF; v.clr = 4'h0; v.sys = 0; v.eret = 0;
      v.pc = 32'h900; v.exp = o_idle(0);
      apply(v, "post_reset_idle0");
      apply(v, "post_reset_no_pending");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
